// File: rtl/bank_pop_arbiter.sv
// bank_pop_arbiter
//
// Picks which per-bank request FIFO to pop each cycle and issues a one-hot
// pop toward the command issue stage. Reads occupy the low ARR_NUM_RD bits of
// every vector and writes the next ARR_NUM_WR bits. A registered read/write
// mode with write-drain hysteresis restricts the candidates to one class.
// Within that class it prefers heads that hit the open row (capped at HIT_MAX
// consecutive hits while a miss waits). Otherwise it drains full FIFOs first,
// then half-full FIFOs, then any nonempty FIFO.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   empty        per-FIFO empty flags
//   full         per-FIFO full flags
//   mid          per-FIFO occupancy >= half
//   first_addr   head row address, FIFO i at [i*RA_BITS +: RA_BITS]
//   ready        issue stage accepts a pop this cycle
//   pop          one-hot pop (combinational); the FIFO consumes on this edge
//   pop_idx      index of the popped FIFO, 0 when nothing pops
//   pop_hit      the popped head matched the open row
//   wr_mode      registered mode, 0 = READ, 1 = WRITE (FSM state)
//   open_row     row of the last popped head
//
// Handshake: a pop is a transfer. pop is nonzero only when ready=1 and a
// candidate exists. The FIFO dequeues and the issue stage captures the
// request on the same rising edge. There is no holding or back-pressure
// beyond ready.
module bank_pop_arbiter #(
  parameter int unsigned RA_BITS      = 8,
  parameter int unsigned ARR_NUM_RD   = 4,
  parameter int unsigned ARR_NUM_WR   = 3,
  parameter int unsigned WR_BURST_MAX = 8,
  parameter int unsigned HIT_MAX      = 4,
  localparam int unsigned N           = ARR_NUM_RD + ARR_NUM_WR,
  localparam int unsigned IDX_W       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         empty,
  input  logic [N-1:0]         full,
  input  logic [N-1:0]         mid,
  input  logic [N*RA_BITS-1:0] first_addr,
  input  logic                 ready,
  output logic [N-1:0]         pop,
  output logic [IDX_W-1:0]     pop_idx,
  output logic                 pop_hit,
  output logic                 wr_mode,
  output logic [RA_BITS-1:0]   open_row
);

  localparam int unsigned HC_W = $clog2(HIT_MAX + 1);
  localparam int unsigned WC_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [HC_W-1:0] HIT_MAX_C = HIT_MAX[HC_W-1:0];
  localparam logic [WC_W-1:0] WR_MAX_C  = WR_BURST_MAX[WC_W-1:0];
  localparam logic [N-1:0] RD_MASK = {{ARR_NUM_WR{1'b0}}, {ARR_NUM_RD{1'b1}}};
  localparam logic [N-1:0] WR_MASK = ~RD_MASK;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  mode_e              mode_q, mode_d;
  logic [RA_BITS-1:0] open_row_q, open_row_d;
  logic               open_valid_q, open_valid_d;
  logic [HC_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [WC_W-1:0]    wr_cnt_q, wr_cnt_d;

  logic [N-1:0]       nonempty, cand, row_match, hit, miss, sel_vec;
  logic               force_miss, take_hit, do_pop;
  logic               any_rd_ne, any_wr_ne, any_wr_full;
  logic [RA_BITS-1:0] popped_row;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [N-1:0] lowest_one(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  assign nonempty    = ~empty;
  assign any_rd_ne   = |(nonempty & RD_MASK);
  assign any_wr_ne   = |(nonempty & WR_MASK);
  assign any_wr_full = |(full & WR_MASK);

  // Candidate selection
  always_comb begin
    row_match = '0;
    for (int i = 0; i < N; i++) begin
      row_match[i] = (first_addr[i*RA_BITS +: RA_BITS] == open_row_q);
    end
    cand = nonempty & ((mode_q == MODE_WRITE) ? WR_MASK : RD_MASK);
    hit  = cand & row_match & {N{open_valid_q}};
    miss = cand & ~hit;

    // After HIT_MAX consecutive hits a waiting miss gets the slot. When no
    // hit exists, miss equals cand, so the fallback tiers always search
    // miss.
    force_miss = (hit_cnt_q == HIT_MAX_C) && (|miss);
    take_hit   = (|hit) && !force_miss;

    if (take_hit)             sel_vec = hit;
    else if (|(miss & full))  sel_vec = miss & full;
    else if (|(miss & mid))   sel_vec = miss & mid;
    else                      sel_vec = miss;

    // rst_n gates the pop so no FIFO consumes while reset is held.
    do_pop = rst_n && ready && (|cand);
    pop    = do_pop ? lowest_one(sel_vec) : '0;

    pop_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pop[i]) pop_idx = IDX_W'(i);
    end
    pop_hit    = |(pop & hit);
    popped_row = first_addr[pop_idx*RA_BITS +: RA_BITS];
  end

  // Next-state: pop bookkeeping and mode FSM
  always_comb begin
    mode_d       = mode_q;
    open_row_d   = open_row_q;
    open_valid_d = open_valid_q;
    hit_cnt_d    = hit_cnt_q;
    wr_cnt_d     = wr_cnt_q;

    if (do_pop) begin
      open_row_d   = popped_row;
      open_valid_d = 1'b1;
      if (pop_hit) begin
        hit_cnt_d = (hit_cnt_q == HIT_MAX_C) ? hit_cnt_q : hit_cnt_q + HC_W'(1);
      end else begin
        hit_cnt_d = '0;
      end
      if (mode_q == MODE_WRITE) begin
        wr_cnt_d = (wr_cnt_q == WR_MAX_C) ? wr_cnt_q : wr_cnt_q + WC_W'(1);
      end
    end

    // Mode decisions use this cycle's flags. They do not anticipate the
    // effect of the pop taken on the same edge.
    case (mode_q)
      MODE_READ: begin
        if (any_wr_full || (!any_rd_ne && any_wr_ne)) begin
          mode_d   = MODE_WRITE;
          wr_cnt_d = '0;
        end
      end
      MODE_WRITE: begin
        if (!any_wr_ne || ((wr_cnt_q == WR_MAX_C) && !any_wr_full && any_rd_ne)) begin
          mode_d = MODE_READ;
        end
      end
      default: mode_d = MODE_READ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_READ;
      open_row_q   <= '0;
      open_valid_q <= 1'b0;
      hit_cnt_q    <= '0;
      wr_cnt_q     <= '0;
    end else begin
      mode_q       <= mode_d;
      open_row_q   <= open_row_d;
      open_valid_q <= open_valid_d;
      hit_cnt_q    <= hit_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  assign wr_mode  = (mode_q == MODE_WRITE);
  assign open_row = open_row_q;

endmodule

// File: tb/tb_bank_pop_arbiter.sv
module tb_bank_pop_arbiter;

  localparam int RA = 8;
  localparam int N  = 7;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    empty, full, mid;
  logic [N*RA-1:0] first_addr;
  logic            ready;
  logic [N-1:0]    pop;
  logic [2:0]      pop_idx;
  logic            pop_hit;
  logic            wr_mode;
  logic [RA-1:0]   open_row;

  bank_pop_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .empty      (empty),
    .full       (full),
    .mid        (mid),
    .first_addr (first_addr),
    .ready      (ready),
    .pop        (pop),
    .pop_idx    (pop_idx),
    .pop_hit    (pop_hit),
    .wr_mode    (wr_mode),
    .open_row   (open_row)
  );

  // Scoreboard: expected pops as {hit, idx[2:0]}
  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented pop against the queue head.
  always @(negedge clk) begin
    logic [3:0]   e;
    logic [N-1:0] exp_pop;
    if (pop !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%b required=none at %0t", pop, $time);
      end else begin
        e = exp_q.pop_front();
        exp_pop = N'(1) << e[2:0];
        check("pop_vec", 32'(pop), 32'(exp_pop));
        check("pop_idx", 32'(pop_idx), 32'(e[2:0]));
        check("pop_hit", 32'(pop_hit), 32'(e[3]));
      end
    end
  end

  // Driver tasks
  task automatic set_idle();
    empty      = '1;
    full       = '0;
    mid        = '0;
    first_addr = '0;
    ready      = 1'b0;
  endtask

  task automatic set_fifo(input int idx, input logic [RA-1:0] row,
                          input logic f, input logic m);
    empty[idx] = 1'b0;
    full[idx]  = f;
    mid[idx]   = m;
    first_addr[idx*RA +: RA] = row;
  endtask

  task automatic expect_pop(input int idx, input logic h);
    exp_q.push_back({h, 3'(idx)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();

    // Reset held: a candidate and ready must still produce no pop
    repeat (2) step();
    set_fifo(2, 8'h15, 1'b0, 1'b0);
    ready = 1'b1;
    #1;
    check("rst_pop", 32'(pop), 32'h0);
    check("rst_pop_idx", 32'(pop_idx), 32'h0);
    check("rst_pop_hit", 32'(pop_hit), 32'h0);
    check("rst_wr_mode", 32'(wr_mode), 32'h0);
    check("rst_open_row", 32'(open_row), 32'h0);

    // First pop after reset is a miss
    expect_pop(2, 1'b0);
    rst_n = 1'b1;
    step();
    check("open_row_after_first", 32'(open_row), 32'h15);

    // Row hit beats a full miss
    set_idle();
    set_fifo(0, 8'h20, 1'b1, 1'b0);
    set_fifo(3, 8'h15, 1'b0, 1'b0);
    ready = 1'b1;
    expect_pop(3, 1'b1);
    step();

    // Two misses: clear the hit streak and reopen row 0x15
    set_idle(); set_fifo(2, 8'h33, 1'b0, 1'b0); ready = 1'b1;
    expect_pop(2, 1'b0);
    step();
    set_idle(); set_fifo(1, 8'h15, 1'b0, 1'b0); ready = 1'b1;
    expect_pop(1, 1'b0);
    step();

    // Hit cap: four hits on FIFO1, forced miss to FIFO0, then FIFO0 row hits
    set_idle();
    set_fifo(0, 8'h40, 1'b0, 1'b0);
    set_fifo(1, 8'h15, 1'b0, 1'b0);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) expect_pop(1, 1'b1);
    expect_pop(0, 1'b0);
    expect_pop(0, 1'b1);
    repeat (6) step();
    check("open_row_after_cap", 32'(open_row), 32'h40);

    // Priority full > mid > nonempty; write FIFO5 must never be popped in READ
    set_idle();
    set_fifo(0, 8'h01, 1'b0, 1'b1);
    set_fifo(1, 8'h02, 1'b0, 1'b0);
    set_fifo(2, 8'h03, 1'b1, 1'b0);
    set_fifo(3, 8'h04, 1'b0, 1'b1);
    set_fifo(5, 8'h70, 1'b0, 1'b0);
    ready = 1'b1;
    expect_pop(2, 1'b0);
    step();
    set_idle();
    set_fifo(1, 8'h02, 1'b0, 1'b0);
    set_fifo(3, 8'h04, 1'b0, 1'b1);
    set_fifo(5, 8'h70, 1'b0, 1'b0);
    ready = 1'b1;
    expect_pop(3, 1'b0);
    step();
    set_idle();
    set_fifo(1, 8'h02, 1'b0, 1'b0);
    set_fifo(3, 8'h09, 1'b0, 1'b0);
    set_fifo(5, 8'h70, 1'b0, 1'b0);
    ready = 1'b1;
    expect_pop(1, 1'b0);
    step();
    check("still_read", 32'(wr_mode), 32'h0);

    // Full write FIFO forces WRITE; next cycle pops FIFO5
    set_idle();
    set_fifo(0, 8'h11, 1'b0, 1'b0);
    set_fifo(5, 8'h55, 1'b1, 1'b0);
    step();
    check("to_write", 32'(wr_mode), 32'h1);
    ready = 1'b1;
    expect_pop(5, 1'b0);
    step();

    // Seven more write pops (8 total): hits on FIFO4, capped, then FIFO6
    set_idle();
    set_fifo(0, 8'h11, 1'b0, 1'b0);
    set_fifo(4, 8'h60, 1'b0, 1'b0);
    set_fifo(6, 8'h61, 1'b0, 1'b0);
    ready = 1'b1;
    expect_pop(4, 1'b0);
    for (int k = 0; k < 4; k++) expect_pop(4, 1'b1);
    expect_pop(6, 1'b0);
    expect_pop(6, 1'b1);
    repeat (7) step();
    check("write_after_8", 32'(wr_mode), 32'h1);
    ready = 1'b0;
    step();
    check("burst_yield", 32'(wr_mode), 32'h0);

    // ready held low in WRITE: mode holds, no pops
    set_idle();
    set_fifo(0, 8'h11, 1'b0, 1'b0);
    set_fifo(5, 8'h55, 1'b1, 1'b0);
    step();
    check("to_write2", 32'(wr_mode), 32'h1);
    set_idle();
    set_fifo(0, 8'h11, 1'b0, 1'b0);
    set_fifo(4, 8'h60, 1'b0, 1'b0);
    set_fifo(5, 8'h55, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_nopop", 32'(pop), 32'h0);
    end
    check("idle_hold_write", 32'(wr_mode), 32'h1);

    // Two FIFO6 hits (row 0x61 still open) bring the hit streak to 3
    set_idle();
    set_fifo(0, 8'h11, 1'b0, 1'b0);
    set_fifo(6, 8'h61, 1'b0, 1'b0);
    ready = 1'b1;
    expect_pop(6, 1'b1);
    expect_pop(6, 1'b1);
    repeat (2) step();

    // Reset mid-episode takes effect immediately
    rst_n = 1'b0;
    #1;
    check("midrst_pop", 32'(pop), 32'h0);
    check("midrst_wr_mode", 32'(wr_mode), 32'h0);
    check("midrst_open_row", 32'(open_row), 32'h0);
    set_idle();
    set_fifo(4, 8'h61, 1'b0, 1'b0);
    ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 32'(pop), 32'h0);
    step();
    check("post_rst_write", 32'(wr_mode), 32'h1);
    expect_pop(4, 1'b0);
    step();
    check("post_rst_row", 32'(open_row), 32'h61);

    set_idle();
    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
